// File: rtl/serial_frame_deserializer_pkg.sv
// Shared definitions for the serial frame deserializer: FSM state encoding,
// line levels and the parity check helper.
package serial_frame_deserializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  localparam logic START_BIT_LEVEL = 1'b1;

  // Non-zero when accumulated data parity plus the parity bit misses the target sense
  function automatic logic parity_mismatch(input logic acc, input logic pbit, input logic odd);
    return (acc ^ pbit) != odd;
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in parallel-out capture register; shifts LSB-first so the first bit
// received ends up in q[0] after WIDTH shifts.
module sipo_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (shift_en) begin
      r_q <= {bit_in, r_q[WIDTH-1:1]};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/serial_frame_deserializer.sv
// Start-bit framed serial receiver: collects WIDTH data bits LSB-first plus an
// optional parity bit and presents each word on a valid/ready output buffer.
module serial_frame_deserializer
  import serial_frame_deserializer_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned ODD_PARITY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_in,
  input  logic             s_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             parity_err,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic             PAR_ON   = (PARITY_EN != 0);
  localparam logic             ODD_BIT  = (ODD_PARITY != 0);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_par;
  logic             r_busy;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_parity_err;
  logic             r_overflow;

  logic             w_shift;
  logic             w_last_data;
  logic             w_complete;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_word;
  logic             w_perr;

  assign w_shift     = s_en && (r_state == ST_DATA);
  assign w_last_data = (r_cnt == LAST_CNT);
  assign w_complete  = s_en && (((r_state == ST_DATA) && w_last_data && !PAR_ON) ||
                                (r_state == ST_PARITY));

  sipo_shift_reg #(
    .WIDTH (WIDTH)
  ) u_sipo (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (w_shift),
    .bit_in   (s_in),
    .q        (w_q)
  );

  // Without a parity bit the word completes on the last data edge, before the shift lands
  assign w_word = (r_state == ST_PARITY) ? w_q : {s_in, w_q[WIDTH-1:1]};
  assign w_perr = PAR_ON ? parity_mismatch(r_par, s_in, ODD_BIT) : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_par   <= 1'b0;
      r_busy  <= 1'b0;
    end else if (s_en) begin
      case (r_state)
        ST_IDLE: begin
          if (s_in == START_BIT_LEVEL) begin
            r_state <= ST_DATA;
            r_cnt   <= '0;
            r_par   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_DATA: begin
          r_par <= r_par ^ s_in;
          if (w_last_data) begin
            r_cnt <= '0;
            if (PAR_ON) begin
              r_state <= ST_PARITY;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Single-entry output buffer; a word completing into a full, stalled buffer is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (w_complete) begin
        if (!r_dout_valid || dout_ready) begin
          r_dout       <= w_word;
          r_parity_err <= w_perr;
          r_dout_valid <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (r_dout_valid && dout_ready) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign parity_err = r_parity_err;
  assign overflow   = r_overflow;
  assign busy       = r_busy;

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Randomized scoreboard bench for serial_frame_deserializer (WIDTH=8, even parity).
module tb_serial_frame_deserializer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         s_in = 1'b0;
  logic         s_en = 1'b0;
  logic         dout_ready = 1'b0;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         parity_err;
  logic         overflow;
  logic         busy;

  int checks = 0;
  int errors = 0;

  // Expected words in delivery order: {parity_err, data}
  logic [W:0] exp_q[$];
  logic       m_valid = 1'b0;
  logic       m_busy = 1'b0;
  int         ready_mode = 1;  // 0 random, 1 always, 2 never, 3 only on final bit

  serial_frame_deserializer #(
    .WIDTH      (W),
    .PARITY_EN  (1),
    .ODD_PARITY (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_in       (s_in),
    .s_en       (s_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .parity_err (parity_err),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of stimulus; the handshake model advances on the same edge
  task automatic step(input logic b, input logic en, input logic last,
                      input logic [W:0] ent, input logic bsy_after);
    logic rdy;
    logic ovf;
    s_in = b;
    s_en = en;
    case (ready_mode)
      0:       rdy = 1'($urandom_range(0, 1));
      1:       rdy = 1'b1;
      2:       rdy = 1'b0;
      default: rdy = last;
    endcase
    dout_ready = rdy;
    @(posedge clk);
    ovf = 1'b0;
    if (en && last) begin
      if (!m_valid || rdy) begin
        exp_q.push_back(ent);
        m_valid = 1'b1;
      end else begin
        ovf = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    m_busy = bsy_after;
    #1;
    chk("dout_valid", 32'(dout_valid), 32'(m_valid));
    chk("overflow", 32'(overflow), 32'(ovf));
    chk("busy", 32'(busy), 32'(m_busy));
  endtask

  // stall_mode: 0 none, 1 one s_en=0 cycle before every bit after the start, 2 random
  task automatic send_frame(input logic [W-1:0] w, input logic flip, input int stall_mode);
    logic [W:0]   ent;
    logic [W+1:0] bits;
    int           n;
    ent  = {flip, w};
    bits = {(^w) ^ flip, w, 1'b1};
    for (int i = 0; i < W + 2; i++) begin
      if (i > 0) begin
        n = (stall_mode == 1) ? 1 : (stall_mode == 2) ? $urandom_range(0, 2) : 0;
        for (int k = 0; k < n; k++) step(1'($urandom), 1'b0, 1'b0, ent, m_busy);
      end
      step(bits[i], 1'b1, 1'(i == W + 1), ent, 1'(i != W + 1));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    s_en = 1'b0;
    s_in = 1'b0;
    dout_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_dout", 32'(dout), 0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_perr", 32'(parity_err), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_valid_hold", 32'(dout_valid), 0);
    chk("rst_busy_hold", 32'(busy), 0);
    rst_n = 1'b1;
    m_valid = 1'b0;
    m_busy = 1'b0;
    exp_q.delete();
  endtask

  // Monitor: a word is checked on the cycle the consumer takes it
  always @(negedge clk) begin
    logic [W:0] e;
    if (rst_n && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", dout);
      end else begin
        e = exp_q.pop_front();
        chk("dout", 32'(dout), 32'(e[W-1:0]));
        chk("parity_err", 32'(parity_err), 32'(e[W]));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    do_reset();
    idle(2);

    ready_mode = 1;
    send_frame(8'hA5, 1'b0, 0);
    idle(3);
    send_frame(8'hA5, 1'b1, 0);
    idle(3);

    ready_mode = 2;
    send_frame(8'h3C, 1'b0, 0);
    send_frame(8'hC3, 1'b0, 0);
    ready_mode = 1;
    idle(3);

    ready_mode = 2;
    send_frame(8'hF0, 1'b0, 0);
    ready_mode = 3;
    send_frame(8'h0F, 1'b0, 0);
    ready_mode = 1;
    idle(3);

    send_frame(8'h81, 1'b0, 1);
    idle(3);

    ready_mode = 2;
    send_frame(8'h12, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'($urandom), 1'b1, 1'b0, '0, 1'b1);
    do_reset();
    ready_mode = 1;
    idle(2);
    send_frame(8'h55, 1'b0, 0);
    idle(3);

    ready_mode = 0;
    for (int f = 0; f < 300; f++) begin
      send_frame(8'($urandom), 1'($urandom_range(0, 3) == 0), 2);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        if ($urandom_range(0, 1) == 1) step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        else step(1'($urandom), 1'b0, 1'b0, '0, 1'b0);
      end
    end

    ready_mode = 1;
    idle(4);
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
